// File: rtl/retro_vending_pkg.sv
// Shared types and helpers for the multi-item vending controller.
// Holds the FSM state enum, coin values, event bit positions and price lookup.
package retro_vending_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam int COIN_5  = 5;
  localparam int COIN_10 = 10;
  localparam int COIN_25 = 25;

  localparam int EV_W   = 7;
  localparam int EV_C5  = 0;
  localparam int EV_C10 = 1;
  localparam int EV_C25 = 2;
  localparam int EV_NXT = 3;
  localparam int EV_SEL = 4;
  localparam int EV_CAN = 5;
  localparam int EV_RST = 6;

  localparam int PRICE_BUS_W = 256;

  // Price of item idx from a packed list of w-bit fields, item 0 at LSBs.
  // The result is zero-extended to 32 bits; callers keep the low w bits.
  function automatic logic [31:0] price_at(
    input logic [PRICE_BUS_W-1:0] list,
    input int unsigned            idx,
    input int unsigned            w
  );
    logic [PRICE_BUS_W-1:0] m;
    m = (PRICE_BUS_W'(1) << w) - PRICE_BUS_W'(1);
    return 32'((list >> (idx * w)) & m);
  endfunction

endpackage

// File: rtl/retro_vending_multi_edge_detect.sv
// Rising-edge detector for a bundle of level inputs.
// Ports: clk, reset (sync, active-low), in (levels), out (one-cycle events).
module edge_detect #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] in_q;

  always_ff @(posedge clk) begin
    if (!reset) in_q <= '0;
    else        in_q <= in;
  end

  assign out = in & ~in_q;

endmodule

// File: rtl/retro_vending_multi.sv
// Multi-item vending controller: credit, per-item stock, vend and change.
// Ports: clk, reset, coin/button levels in; item_sel, credit, pulses, busy out.
module retro_vending_multi
  import retro_vending_pkg::*;
#(
  parameter int N_ITEMS    = 4,
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 100,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 5,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICE_LIST =
    {8'd65, 8'd50, 8'd35, 8'd25},
  localparam int IW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_5,
  input  logic                coin_10,
  input  logic                coin_25,
  input  logic                next_item,
  input  logic                select,
  input  logic                cancel,
  input  logic                restock,
  output logic [IW-1:0]       item_sel,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                change_5,
  output logic                change_10,
  output logic                change_25,
  output logic                coin_reject,
  output logic                sold_out,
  output logic                busy
);

  localparam logic [PRICE_BUS_W-1:0] PL_EXT =
    PRICE_BUS_W'(PRICE_LIST);
  localparam logic [CREDIT_W-1:0] C5  = CREDIT_W'(COIN_5);
  localparam logic [CREDIT_W-1:0] C10 = CREDIT_W'(COIN_10);
  localparam logic [CREDIT_W-1:0] C25 = CREDIT_W'(COIN_25);
  localparam logic [CREDIT_W-1:0] CMAX = CREDIT_W'(MAX_CREDIT);
  localparam logic [STOCK_W-1:0]  SINIT = STOCK_W'(STOCK_INIT);

  logic [EV_W-1:0] lvl;
  logic [EV_W-1:0] ev;

  assign lvl = {restock, cancel, select, next_item,
                coin_25, coin_10, coin_5};

  edge_detect #(.WIDTH(EV_W)) u_edge (
    .clk   (clk),
    .reset (reset),
    .in    (lvl),
    .out   (ev)
  );

  state_t              state, state_n;
  logic [STOCK_W-1:0]  stock   [N_ITEMS];
  logic [STOCK_W-1:0]  stock_n [N_ITEMS];
  logic [CREDIT_W-1:0] credit_n;
  logic [CREDIT_W-1:0] credit_a;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic [31:0]         price32;
  logic [IW-1:0]       item_n;
  logic                disp_n, c5_n, c10_n, c25_n;
  logic                rej_n, sold_n, busy_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      credit      <= '0;
      item_sel    <= '0;
      for (int i = 0; i < N_ITEMS; i++) stock[i] <= SINIT;
      dispense    <= 1'b0;
      change_5    <= 1'b0;
      change_10   <= 1'b0;
      change_25   <= 1'b0;
      coin_reject <= 1'b0;
      sold_out    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      credit      <= credit_n;
      item_sel    <= item_n;
      stock       <= stock_n;
      dispense    <= disp_n;
      change_5    <= c5_n;
      change_10   <= c10_n;
      change_25   <= c25_n;
      coin_reject <= rej_n;
      sold_out    <= sold_n;
      busy        <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    credit_n = credit;
    item_n   = item_sel;
    stock_n  = stock;
    disp_n   = 1'b0;
    c5_n     = 1'b0;
    c10_n    = 1'b0;
    c25_n    = 1'b0;
    rej_n    = 1'b0;
    sold_n   = 1'b0;
    coin_val = '0;
    credit_a = credit;
    sum      = '0;
    price32  = price_at(PL_EXT, 32'(item_sel), CREDIT_W);

    unique case (state)
      IDLE: begin
        // Only the largest coin of a same-cycle group counts.
        priority case (1'b1)
          ev[EV_C25]: coin_val = C25;
          ev[EV_C10]: coin_val = C10;
          ev[EV_C5]:  coin_val = C5;
          default:    coin_val = '0;
        endcase

        // Credit never exceeds MAX_CREDIT, so the sum fits CREDIT_W.
        sum = credit + coin_val;
        if (coin_val != '0) begin
          if (sum > CMAX) rej_n    = 1'b1;
          else            credit_a = sum;
        end
        credit_n = credit_a;

        priority case (1'b1)
          ev[EV_SEL]: begin
            if (stock[item_sel] == '0) begin
              sold_n = 1'b1;
            end else if (32'(credit_a) >= price32) begin
              credit_n = credit_a - price32[CREDIT_W-1:0];
              stock_n[item_sel] = stock[item_sel] - 1'b1;
              state_n = VEND;
              disp_n  = 1'b1;
            end
          end
          ev[EV_CAN]: begin
            if (credit_a != '0) state_n = CHANGE;
          end
          ev[EV_NXT]: begin
            if (item_sel == IW'(N_ITEMS - 1)) item_n = '0;
            else                              item_n = item_sel + 1'b1;
          end
          ev[EV_RST]: begin
            for (int i = 0; i < N_ITEMS; i++) stock_n[i] = SINIT;
          end
          default: ;
        endcase
      end

      VEND: begin
        state_n = (credit != '0) ? CHANGE : IDLE;
      end

      CHANGE: begin
        priority case (1'b1)
          (credit >= C25): begin
            c25_n    = 1'b1;
            credit_n = credit - C25;
          end
          (credit >= C10): begin
            c10_n    = 1'b1;
            credit_n = credit - C10;
          end
          (credit >= C5): begin
            c5_n     = 1'b1;
            credit_n = credit - C5;
          end
          default: credit_n = '0;
        endcase
        state_n = (credit_n == '0) ? IDLE : CHANGE;
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_retro_vending_multi.sv
// Directed self-checking bench for retro_vending_multi.
// A second instance with STOCK_INIT=1 covers the sold-out path.
module tb_retro_vending_multi;
  import retro_vending_pkg::*;

  localparam logic [6:0] B_C5  = 7'b0000001;
  localparam logic [6:0] B_C10 = 7'b0000010;
  localparam logic [6:0] B_C25 = 7'b0000100;
  localparam logic [6:0] B_NXT = 7'b0001000;
  localparam logic [6:0] B_SEL = 7'b0010000;
  localparam logic [6:0] B_CAN = 7'b0100000;
  localparam logic [6:0] B_RST = 7'b1000000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] ins = '0;

  logic [1:0] item_sel, item_sel1;
  logic [7:0] credit, credit1;
  logic dispense, change_5, change_10, change_25;
  logic coin_reject, sold_out, busy;
  logic dispense1, ch5_1, ch10_1, ch25_1;
  logic rej1, sold1, busy1;

  int n_chk  = 0;
  int n_fail = 0;
  int dcount;

  always #5 clk = ~clk;

  retro_vending_multi dut (
    .clk(clk), .reset(reset),
    .coin_5(ins[0]), .coin_10(ins[1]), .coin_25(ins[2]),
    .next_item(ins[3]), .select(ins[4]),
    .cancel(ins[5]), .restock(ins[6]),
    .item_sel(item_sel), .credit(credit),
    .dispense(dispense),
    .change_5(change_5), .change_10(change_10),
    .change_25(change_25),
    .coin_reject(coin_reject), .sold_out(sold_out),
    .busy(busy)
  );

  retro_vending_multi #(.STOCK_INIT(1)) dut1 (
    .clk(clk), .reset(reset),
    .coin_5(ins[0]), .coin_10(ins[1]), .coin_25(ins[2]),
    .next_item(ins[3]), .select(ins[4]),
    .cancel(ins[5]), .restock(ins[6]),
    .item_sel(item_sel1), .credit(credit1),
    .dispense(dispense1),
    .change_5(ch5_1), .change_10(ch10_1),
    .change_25(ch25_1),
    .coin_reject(rej1), .sold_out(sold1),
    .busy(busy1)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One low cycle, then the inputs for one cycle; returns where
  // the effect of the event is visible.
  task automatic press(input logic [6:0] v);
    @(negedge clk);
    ins = v;
    @(negedge clk);
    ins = '0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    ins   = '0;
    repeat (2) @(negedge clk);
    check("rst_credit", credit, 0);
    check("rst_item", item_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_disp", dispense, 0);
    check("rst_stock0", dut.stock[0], 5);
    reset = 1'b1;

    // Buy item 1 (35) with 50, select held 10 cycles.
    press(B_C25);
    check("c25_a", credit, 25);
    press(B_C25);
    check("c25_b", credit, 50);
    press(B_NXT);
    check("next_1", item_sel, 1);
    @(negedge clk);
    ins = B_SEL;
    @(negedge clk);
    check("vend_disp", dispense, 1);
    check("vend_credit", credit, 15);
    check("vend_busy", busy, 1);
    @(negedge clk);
    check("vend_disp_off", dispense, 0);
    check("vend_gap_credit", credit, 15);
    @(negedge clk);
    check("chg_10", change_10, 1);
    check("chg_10_credit", credit, 5);
    @(negedge clk);
    check("chg_5", change_5, 1);
    check("chg_5_credit", credit, 0);
    check("chg_busy_off", busy, 0);
    dcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (dispense) dcount++;
    end
    ins = '0;
    check("held_sel_once", dcount, 0);
    check("stock1", dut.stock[1], 4);

    // Credit ceiling and multi-coin priority.
    repeat (4) press(B_C25);
    check("max_credit", credit, 100);
    press(B_C25);
    check("over_credit", credit, 100);
    check("over_reject", coin_reject, 1);
    @(negedge clk);
    check("reject_pulse", coin_reject, 0);
    press(B_CAN);
    check("refund_busy", busy, 1);
    wait_idle("refund_done");
    check("refund_credit", credit, 0);
    press(B_C5 | B_C25);
    check("multi_coin", credit, 25);

    // Refund 40 as 25, 10, 5.
    press(B_C10);
    press(B_C5);
    check("ins_40", credit, 40);
    press(B_CAN);
    check("can_busy", busy, 1);
    check("can_nochg", {change_25, change_10, change_5}, 0);
    @(negedge clk);
    check("ref_25", {change_25, change_10, change_5}, 3'b100);
    check("ref_25_cr", credit, 15);
    @(negedge clk);
    check("ref_10", {change_25, change_10, change_5}, 3'b010);
    check("ref_10_cr", credit, 5);
    @(negedge clk);
    check("ref_5", {change_25, change_10, change_5}, 3'b001);
    check("ref_5_cr", credit, 0);
    check("ref_no_disp", dispense, 0);
    check("ref_idle", busy, 0);

    // Item wrap, underfunded select, coin while busy.
    press(B_NXT);
    check("next_2", item_sel, 2);
    press(B_NXT);
    check("next_3", item_sel, 3);
    press(B_NXT);
    check("next_wrap", item_sel, 0);
    press(B_C10);
    press(B_SEL);
    check("poor_credit", credit, 10);
    check("poor_disp", dispense, 0);
    check("poor_busy", busy, 0);
    press(B_C25);
    check("cr_35", credit, 35);
    press(B_SEL);
    check("buy0_disp", dispense, 1);
    check("buy0_credit", credit, 10);
    ins = B_C25;
    @(negedge clk);
    check("busy_coin_cr", credit, 10);
    check("busy_coin_rej", coin_reject, 0);
    ins = '0;
    @(negedge clk);
    check("busy_chg10", change_10, 1);
    check("busy_cr0", credit, 0);
    wait_idle("busy_done");

    // Reset during the first CHANGE cycle of a 40 refund.
    press(B_C25);
    press(B_C10);
    press(B_C5);
    press(B_CAN);
    check("mid_state", dut.state, CHANGE);
    reset = 1'b0;
    @(negedge clk);
    check("mid_credit", credit, 0);
    check("mid_chg", {change_25, change_10, change_5}, 0);
    check("mid_busy", busy, 0);
    check("mid_state_idle", dut.state, IDLE);
    for (int i = 0; i < 4; i++)
      check("mid_stock", dut.stock[i], 5);
    reset = 1'b1;

    // Sold out with STOCK_INIT=1 on the second instance.
    press(B_C25);
    check("so_cr", credit1, 25);
    press(B_SEL);
    check("so_disp1", dispense1, 1);
    check("so_cr0", credit1, 0);
    press(B_C25);
    check("so_cr25", credit1, 25);
    press(B_SEL);
    check("so_pulse", sold1, 1);
    check("so_nodisp", dispense1, 0);
    check("so_keep_cr", credit1, 25);
    check("main_stock0", dut.stock[0], 3);

    // next_item outranks restock; restock alone reloads.
    press(B_NXT | B_RST);
    check("pri_item", item_sel, 1);
    check("pri_stock", dut.stock[0], 3);
    press(B_RST);
    check("restock", dut.stock[0], 5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
